// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
//
// Resolves load-use hazards, taken branches resolved in EX, and structural hazards on the
// multi-cycle multiply/divide unit. Stall/flush controls are same-cycle functions of the inputs
// and the multiply/divide tracking state.
//
// Build option: define HAZ_MD_EN to build the multiply/divide busy tracker (BUSY/IDLE FSM plus
// down-counter). Without it, md_busy/md_done are tied low and ex_md_start, id_md_op and
// MD_CYCLES are ignored.
//
// Parameters:
//   MD_CYCLES        multiply/divide occupancy in cycles (2..64)
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   id_rs, id_rt     source register fields of the ID instruction
//   id_uses_rs/rt    ID instruction reads rs / rt
//   id_md_op         ID instruction needs the multiply/divide unit or HI/LO
//   ex_MemRead       EX instruction is a load
//   ex_RegWrite      EX instruction writes a register
//   ex_RegAddr       EX destination register
//   ex_branch_taken  branch/jump in EX resolved taken
//   ex_md_start      EX instruction starts a multiply/divide
//   pc_stall         hold PC
//   ifid_stall       hold IF/ID
//   ifid_flush       zero IF/ID on the next edge
//   idex_flush       bubble into ID/EX
//   md_busy          multiply/divide unit occupied
//   md_done          pulse in the final busy cycle
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_md_op,
  input  logic       ex_MemRead,
  input  logic       ex_RegWrite,
  input  logic [4:0] ex_RegAddr,
  input  logic       ex_branch_taken,
  input  logic       ex_md_start,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       md_busy,
  output logic       md_done
);

  logic w_lu;
  logic w_mdh;
  logic w_busy;
  logic w_done;

  // r0 is never a real producer, so a load into r0 cannot create a dependency.
  assign w_lu = ex_MemRead && ex_RegWrite && (ex_RegAddr != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_RegAddr)) ||
                 (id_uses_rt && (id_rt == ex_RegAddr)));

`ifdef HAZ_MD_EN
  localparam int unsigned CntW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MD_CYCLES - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (ex_md_start) begin
            r_state <= StBusy;
            r_cnt   <= CntLoad;
          end
        end
        StBusy: begin
          // A start while busy restarts the occupancy window.
          if (ex_md_start) begin
            r_cnt <= CntLoad;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign w_busy = (r_state == StBusy);
  assign w_done = w_busy && (r_cnt == '0);
  // The final busy cycle releases the dependent op: it reaches EX as the result becomes valid.
  assign w_mdh  = id_md_op && ((w_busy && (r_cnt != '0)) || ex_md_start);
`else
  logic w_unused;

  assign w_busy   = 1'b0;
  assign w_done   = 1'b0;
  assign w_mdh    = 1'b0;
  assign w_unused = ex_md_start ^ id_md_op ^ (MD_CYCLES == 0) ^ clk;
`endif

  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    if (!rst) begin
      md_busy = w_busy;
      md_done = w_done;
      // A taken branch makes the ID instruction wrong-path, so its hazards are moot.
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_lu || w_mdh) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_RegAddr;
  logic       id_uses_rs, id_uses_rt, id_md_op;
  logic       ex_MemRead, ex_RegWrite, ex_branch_taken, ex_md_start;
  logic       pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, md_done;

  int total = 0;
  int bad   = 0;
  bit md_en;

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_md_op       (id_md_op),
    .ex_MemRead     (ex_MemRead),
    .ex_RegWrite    (ex_RegWrite),
    .ex_RegAddr     (ex_RegAddr),
    .ex_branch_taken(ex_branch_taken),
    .ex_md_start    (ex_md_start),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .md_busy        (md_busy),
    .md_done        (md_done)
  );

  // Observed vector order: {pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, md_done}
  task automatic chk(input string tag, input logic [5:0] expv);
    logic [5:0] obs;
    obs = {pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy, md_done};
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_RegAddr = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_md_op = 1'b0;
    ex_MemRead = 1'b0; ex_RegWrite = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
  endtask

  task automatic set_lu();
    ex_MemRead = 1'b1; ex_RegWrite = 1'b1; ex_RegAddr = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  initial begin
`ifdef HAZ_MD_EN
    md_en = 1'b1;
`else
    md_en = 1'b0;
`endif
    rst = 1'b1;
    clear_inputs();
    set_lu();
    #3;
    chk("reset_forces_zero", 6'b000000);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    #1 chk("idle_after_reset", 6'b000000);

    // Load-use family
    set_lu();
    #1 chk("lu_rs", 6'b110100);
    ex_RegAddr = 5'd0; id_rs = 5'd0;
    #1 chk("lu_r0", 6'b000000);
    ex_RegAddr = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
    #1 chk("lu_no_use_rs", 6'b000000);
    id_rt = 5'd7; id_uses_rt = 1'b1; ex_RegAddr = 5'd7;
    #1 chk("lu_rt", 6'b110100);
    ex_RegWrite = 1'b0;
    #1 chk("lu_no_regwrite", 6'b000000);
    ex_RegWrite = 1'b1; ex_MemRead = 1'b0;
    #1 chk("lu_no_memread", 6'b000000);
    clear_inputs();
    set_lu();
    ex_branch_taken = 1'b1;
    #1 chk("branch_over_lu", 6'b001100);
    ex_branch_taken = 1'b0;
    #1 chk("lu_stall_cycle", 6'b110100);
    next_cycle();
    // Load moved to MEM, EX now holds the bubble
    clear_inputs();
    id_rs = 5'd5; id_uses_rs = 1'b1;
    #1 chk("lu_released", 6'b000000);

    // Multiply/divide with a dependent op held in ID from the start cycle
    next_cycle();
    clear_inputs();
    ex_md_start = 1'b1; id_md_op = 1'b1;
    #1 chk("md_start_stall", md_en ? 6'b110100 : 6'b000000);
    next_cycle();
    ex_md_start = 1'b0;
    #1 chk("md_busy1", md_en ? 6'b110110 : 6'b000000);
    next_cycle();
    #1 chk("md_busy2", md_en ? 6'b110110 : 6'b000000);
    next_cycle();
    #1 chk("md_busy3", md_en ? 6'b110110 : 6'b000000);
    next_cycle();
    #1 chk("md_done_release", md_en ? 6'b000011 : 6'b000000);
    next_cycle();
    id_md_op = 1'b0;
    #1 chk("md_idle", 6'b000000);

    // Branch while busy at cnt=2: flush wins, counter keeps running
    next_cycle();
    ex_md_start = 1'b1;
    #1 chk("md2_start_nodep", 6'b000000);
    next_cycle();
    ex_md_start = 1'b0;
    #1 chk("md2_cnt3", md_en ? 6'b000010 : 6'b000000);
    next_cycle();
    ex_branch_taken = 1'b1; id_md_op = 1'b1;
    #1 chk("md2_branch_cnt2", md_en ? 6'b001110 : 6'b001100);
    next_cycle();
    ex_branch_taken = 1'b0; id_md_op = 1'b0;
    #1 chk("md2_cnt1", md_en ? 6'b000010 : 6'b000000);
    next_cycle();
    #1 chk("md2_done", md_en ? 6'b000011 : 6'b000000);
    next_cycle();
    #1 chk("md2_idle", 6'b000000);

    // Asynchronous reset at cnt=1
    next_cycle();
    ex_md_start = 1'b1;
    next_cycle();
    ex_md_start = 1'b0;
    next_cycle();
    next_cycle();
    id_md_op = 1'b1;
    set_lu();
    #1 chk("md3_cnt1_pre_rst", md_en ? 6'b110110 : 6'b110100);
    rst = 1'b1;
    #1 chk("md3_async_rst", 6'b000000);
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    #1 chk("md3_after_rst", 6'b000000);
    next_cycle();
    #1 chk("md3_no_done", 6'b000000);
    next_cycle();
    #1 chk("md3_still_idle", 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
